// File: rtl/manchester_tx_frame_sched.sv
// Frame scheduler and two-channel arbiter feeding the Manchester encoder bit interface.
// Each granted word goes out as preamble, sync, channel id, payload MSB-first, then even parity.
module manchester_tx_frame_sched #(
  parameter int unsigned PREAMBLE_BITS = 8,
  parameter logic [7:0]  SYNC_WORD     = 8'hD5,
  parameter int unsigned GAP_CYCLES    = 8,
  parameter bit          RR_ENABLE     = 1'b1
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        enable,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic        tx_en,
  output logic        bit_in,
  output logic        bit_valid,
  input  logic        bit_ready,
  output logic        busy,
  output logic        grant_id,
  output logic        frame_done,
  output logic [15:0] frames_sent
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SYNC, S_CHID, S_PAYLOAD, S_PARITY, S_GAP
  } state_t;

  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_BITS - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] SYNC     = SYNC_WORD;

  state_t      state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        chid_q, chid_d;
  logic        last_q, last_d;
  logic        bit_q, bit_d;
  logic        grant_q, grant_d;
  logic        done_q, done_d;
  logic [15:0] frames_sent_q, frames_sent_d;

  logic tx_state, hs, grant_ok, pick1;

  assign tx_state = (state_q == S_PREAMBLE) || (state_q == S_SYNC) || (state_q == S_CHID) ||
                    (state_q == S_PAYLOAD) || (state_q == S_PARITY);
  assign hs       = tx_state & bit_ready;
  assign grant_ok = (state_q == S_IDLE) & enable & (req0_valid | req1_valid);
  // On a tie, last_q=1 (ch1 served last) hands the grant to ch0.
  assign pick1    = (req0_valid & req1_valid) ? (RR_ENABLE ? ~last_q : 1'b0) : req1_valid;

  assign req0_ready  = grant_ok & ~pick1;
  assign req1_ready  = grant_ok & pick1;
  assign tx_en       = tx_state;
  assign bit_valid   = tx_state;
  assign bit_in      = bit_q;
  assign busy        = (state_q != S_IDLE);
  assign grant_id    = grant_q;
  assign frame_done  = done_q;
  assign frames_sent = frames_sent_q;

  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    idx_d         = idx_q;
    gap_cnt_d     = gap_cnt_q;
    data_d        = data_q;
    chid_d        = chid_q;
    last_d        = last_q;
    bit_d         = bit_q;
    grant_d       = grant_q;
    done_d        = 1'b0;
    frames_sent_d = frames_sent_q;
    case (state_q)
      S_IDLE: begin
        if (grant_ok) begin
          state_d   = S_PREAMBLE;
          data_d    = pick1 ? req1_data : req0_data;
          chid_d    = pick1;
          grant_d   = pick1;
          last_d    = pick1;
          pre_cnt_d = 6'd0;
          bit_d     = 1'b1;
        end
      end
      S_PREAMBLE: begin
        if (hs) begin
          if (pre_cnt_q == PRE_LAST) begin
            state_d = S_SYNC;
            idx_d   = 3'd7;
            bit_d   = SYNC[7];
          end else begin
            pre_cnt_d = pre_cnt_q + 6'd1;
            // Bit k of the preamble is 1 for even k, so bit k+1 equals k's LSB.
            bit_d     = pre_cnt_q[0];
          end
        end
      end
      S_SYNC: begin
        if (hs) begin
          if (idx_q == 3'd0) begin
            state_d = S_CHID;
            bit_d   = chid_q;
          end else begin
            idx_d = idx_q - 3'd1;
            bit_d = SYNC[idx_q - 3'd1];
          end
        end
      end
      S_CHID: begin
        if (hs) begin
          state_d = S_PAYLOAD;
          idx_d   = 3'd7;
          bit_d   = data_q[7];
        end
      end
      S_PAYLOAD: begin
        if (hs) begin
          if (idx_q == 3'd0) begin
            state_d = S_PARITY;
            bit_d   = chid_q ^ (^data_q);
          end else begin
            idx_d = idx_q - 3'd1;
            bit_d = data_q[idx_q - 3'd1];
          end
        end
      end
      S_PARITY: begin
        if (hs) begin
          state_d       = S_GAP;
          bit_d         = 1'b0;
          gap_cnt_d     = 8'd0;
          done_d        = 1'b1;
          frames_sent_d = (frames_sent_q == 16'hFFFF) ? 16'hFFFF : frames_sent_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pre_cnt_q     <= 6'd0;
      idx_q         <= 3'd0;
      gap_cnt_q     <= 8'd0;
      data_q        <= 8'd0;
      chid_q        <= 1'b0;
      last_q        <= 1'b1;
      bit_q         <= 1'b0;
      grant_q       <= 1'b0;
      done_q        <= 1'b0;
      frames_sent_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      idx_q         <= idx_d;
      gap_cnt_q     <= gap_cnt_d;
      data_q        <= data_d;
      chid_q        <= chid_d;
      last_q        <= last_d;
      bit_q         <= bit_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      frames_sent_q <= frames_sent_d;
    end
  end

endmodule

// File: doc/manchester_tx_frame_sched.md
Name: manchester_tx_frame_sched

Overview:
Frame scheduler and two-channel arbiter in front of the 100 MHz Manchester encoder. Accepts 8-bit words from a control requester (ch0) and a data requester (ch1), and arbitrates between them round-robin or fixed-priority. Wraps each granted word in a frame: preamble, sync word, channel-id bit, payload MSB-first, even parity. Streams the frame bit-by-bit over the encoder's valid/ready bit interface, controls encoder tx_en, and enforces an idle gap between frames.

Parameters:
PREAMBLE_BITS, 8, number of alternating preamble bits, starting with 1 (1,0,1,0,...); range 2..63.
SYNC_WORD, 8'hD5, 8-bit sync pattern, sent MSB first.
GAP_CYCLES, 8, clk_sys cycles with tx_en low after each frame; range 1..255.
RR_ENABLE, 1, 1 = round-robin arbitration; 0 = fixed priority with ch0 always winning.

Ports:
clk_sys  in  1  system clock (100 MHz).
rst  in  1  synchronous reset, active-high.
enable  in  1  allows new grants; sampled only in IDLE.
req0_valid  in  1  ch0 word available.
req0_data  in  8  ch0 word.
req0_ready  out  1  ch0 word accepted this cycle.
req1_valid  in  1  ch1 word available.
req1_data  in  8  ch1 word.
req1_ready  out  1  ch1 word accepted this cycle.
tx_en  out  1  encoder transmit enable.
bit_in  out  1  current bit to encoder.
bit_valid  out  1  bit_in valid.
bit_ready  in  1  encoder accepted bit_in this cycle.
busy  out  1  high in any state other than IDLE.
grant_id  out  1  channel of the current or most recent frame.
frame_done  out  1  one-cycle pulse on the handshake of the parity bit.
frames_sent  out  16  frames completed; saturates at 16'hFFFF.

Behaviour:
- Reset (synchronous, rst=1 at a clk_sys edge):
  - State goes to IDLE.
  - All outputs go to 0: tx_en, bit_in, bit_valid, reqX_ready, busy, grant_id, frame_done, frames_sent.
  - Round-robin pointer is set to "last = ch1", so ch0 wins the first tie.
  - Any latched word is discarded. Reset mid-frame aborts immediately; encoder outputs drop on that same edge.
- States: IDLE -> PREAMBLE -> SYNC -> CHID -> PAYLOAD -> PARITY -> GAP -> IDLE.
- IDLE:
  - Requires enable=1 and at least one reqX_valid.
  - Winner selection: if only one channel is valid, it wins. If both are valid, the winner is ch0 when RR_ENABLE=0; otherwise it is the channel not granted last.
  - reqX_ready is combinational and high in that same IDLE cycle for the winner only; that cycle is the handshake.
  - On the handshake: latch the data and the channel id, update grant_id and the RR pointer, and move to PREAMBLE on the next edge.
  - If enable=0 or no request is valid, stay in IDLE; both reqX_ready stay 0.
- Transmit states (PREAMBLE through PARITY):
  - tx_en=1 and bit_valid=1 continuously.
  - bit_in is registered and changes only on the cycle after a handshake (bit_valid & bit_ready). It is held stable for any stall length.
  - One bit advances per handshake; there is no assumption about cycles per bit.
  - bit_ready is ignored outside transmit states.
- Bit order:
  - PREAMBLE_BITS alternating bits starting with 1.
  - SYNC_WORD[7:0].
  - Channel id (0 or 1).
  - Latched payload[7:0].
  - Parity = XOR of channel id and payload[7:0] (even parity over those 9 bits).
  - Default frame length: 8 + 8 + 1 + 8 + 1 = 26 bits.
- Counters: a 6-bit preamble counter and a 3-bit shift index; they wrap only at state boundaries.
- Parity handshake:
  - frame_done pulses for 1 cycle.
  - frames_sent increments by 1, saturating.
  - On the next edge: GAP, with tx_en=0, bit_valid=0, bit_in=0.
- GAP: lasts exactly GAP_CYCLES cycles, then IDLE. tx_en is therefore low for at least GAP_CYCLES+1 cycles between frames, the extra cycle being the IDLE grant cycle.
- enable deasserted mid-frame: the current frame and its gap complete normally; no new grant follows.
- reqX_valid and reqX_data changes after the grant have no effect on the frame in flight.
- busy=0 only in IDLE.

Test Plan:
- Single ch0 frame: enable=1, req0 word 0xA5, bit_ready stub pulsing every 4th cycle -> req0_ready one pulse. Sampled bits 10101010 11010101 0 10100101 0. frame_done one pulse; frames_sent=1; tx_en low for 8 cycles after.
- Arbitration: req0 and req1 held valid (0x11/0x22), RR_ENABLE=1 -> grants ch0, ch1, ch0, ch1; CHID bits 0,1,0,1; ch1 parity bit=1. With RR_ENABLE=0 -> four ch0 grants and req1_ready never high.
- Stall: hold bit_ready low 20 cycles mid-PAYLOAD -> bit_in/bit_valid/tx_en constant throughout, and the next handshake yields the following payload bit, no skip or duplicate.
- Reset mid-frame: assert rst during PAYLOAD -> after that edge tx_en=0, bit_valid=0, busy=0, frames_sent=0. With req1 still valid after release, a new frame starts from preamble and ch0 retains RR priority.
- Enable gating: enable=0 with both reqs valid for 50 cycles -> no reqX_ready, tx_en=0. Deassert enable during SYNC -> that frame completes (frame_done=1), then stays IDLE.
- Saturation: preload or force 65535 frames -> frames_sent stays 16'hFFFF after the next frame_done.
